// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator between a MIDI event parser and a synth engine.
//
// Each incoming MIDI event is handled one at a time. The block accepts an
// event, walks the slot table one slot per cycle, and then issues a single
// one-cycle pulse to the synth.
//
// Ports:
//   clk96, rst          - 96 MHz clock and synchronous active-high reset
//   in_valid/in_ready   - event handshake; an event is accepted on in_valid && in_ready
//   in_cmd              - 0=NOTE_ON 1=NOTE_OFF 2=POLY_AT 3=PITCH
//   in_channel, in_note, in_velocity - event fields (in_note carries the bend MSB for PITCH)
//   note_pressed, note_released, note_keypress, pitch_wheel - one-cycle pulses to the synth
//   note, velocity, channel, addr - event fields and voice slot; held until the next issue
//   voices_active       - number of occupied slots
module voice_alloc #(
  parameter int NUM_VOICES = 32
) (
  input  logic       clk96,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_cmd,
  input  logic [3:0] in_channel,
  input  logic [6:0] in_note,
  input  logic [6:0] in_velocity,
  output logic       note_pressed,
  output logic       note_released,
  output logic       note_keypress,
  output logic       pitch_wheel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] addr,
  output logic [7:0] voices_active
);

  localparam int IW = $clog2(NUM_VOICES);

  localparam logic [1:0] CMD_ON    = 2'd0;
  localparam logic [1:0] CMD_OFF   = 2'd1;
  localparam logic [1:0] CMD_POLY  = 2'd2;
  localparam logic [1:0] CMD_PITCH = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t          state_reg;
  logic [1:0]      ev_cmd_reg;
  logic [3:0]      ev_chan_reg;
  logic [6:0]      ev_note_reg;
  logic [6:0]      ev_vel_reg;
  logic [IW-1:0]   scan_idx_reg;
  logic [IW-1:0]   match_idx_reg;
  logic [IW-1:0]   free_idx_reg;
  logic [IW-1:0]   steal_ptr_reg;
  logic            match_found_reg;
  logic            free_found_reg;

  logic [NUM_VOICES-1:0] slot_active;
  logic [3:0]            slot_chan [NUM_VOICES];
  logic [6:0]            slot_note [NUM_VOICES];

  logic          cur_active;
  logic          cur_match;
  logic [IW-1:0] on_slot;
  logic          use_steal;
  logic          tbl_set;
  logic          tbl_clr;
  logic [IW-1:0] tbl_idx;

  assign in_ready = (state_reg == IDLE);

  // Slot under examination this SCAN cycle.
  assign cur_active = slot_active[scan_idx_reg];
  assign cur_match  = cur_active && (slot_chan[scan_idx_reg] == ev_chan_reg) &&
                      (slot_note[scan_idx_reg] == ev_note_reg);

  // NOTE_ON target: retrigger a matching voice, else the lowest free slot,
  // else steal round-robin.
  always_comb begin
    use_steal = !match_found_reg && !free_found_reg;
    on_slot   = match_found_reg ? match_idx_reg :
                (free_found_reg ? free_idx_reg : steal_ptr_reg);
    tbl_set   = 1'b0;
    tbl_clr   = 1'b0;
    tbl_idx   = on_slot;
    if (state_reg == ISSUE) begin
      if (ev_cmd_reg == CMD_ON) begin
        tbl_set = 1'b1;
      end else if (ev_cmd_reg == CMD_OFF && match_found_reg) begin
        tbl_clr = 1'b1;
        tbl_idx = match_idx_reg;
      end
    end
  end

  // The table only changes in ISSUE. A whole scan therefore sees a consistent snapshot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      logic       act_reg;
      logic [3:0] chan_reg;
      logic [6:0] note_reg;

      always_ff @(posedge clk96) begin
        if (rst) begin
          act_reg  <= 1'b0;
          chan_reg <= 4'd0;
          note_reg <= 7'd0;
        end else if (tbl_idx == IW'(gi)) begin
          if (tbl_set) begin
            act_reg  <= 1'b1;
            chan_reg <= ev_chan_reg;
            note_reg <= ev_note_reg;
          end else if (tbl_clr) begin
            act_reg <= 1'b0;
          end
        end
      end

      assign slot_active[gi] = act_reg;
      assign slot_chan[gi]   = chan_reg;
      assign slot_note[gi]   = note_reg;
    end
  endgenerate

  always_ff @(posedge clk96) begin
    if (rst) begin
      state_reg       <= IDLE;
      ev_cmd_reg      <= CMD_ON;
      ev_chan_reg     <= 4'd0;
      ev_note_reg     <= 7'd0;
      ev_vel_reg      <= 7'd0;
      scan_idx_reg    <= '0;
      match_idx_reg   <= '0;
      free_idx_reg    <= '0;
      steal_ptr_reg   <= '0;
      match_found_reg <= 1'b0;
      free_found_reg  <= 1'b0;
      note_pressed    <= 1'b0;
      note_released   <= 1'b0;
      note_keypress   <= 1'b0;
      pitch_wheel     <= 1'b0;
      note            <= 7'd0;
      velocity        <= 7'd0;
      channel         <= 4'd0;
      addr            <= 8'd0;
      voices_active   <= 8'd0;
    end else begin
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      note_keypress <= 1'b0;
      pitch_wheel   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // A zero-velocity NOTE_ON is a NOTE_OFF in running-status MIDI.
            ev_cmd_reg      <= (in_cmd == CMD_ON && in_velocity == 7'd0) ? CMD_OFF : in_cmd;
            ev_chan_reg     <= in_channel;
            ev_note_reg     <= in_note;
            ev_vel_reg      <= in_velocity;
            scan_idx_reg    <= '0;
            match_found_reg <= 1'b0;
            free_found_reg  <= 1'b0;
            state_reg       <= (in_cmd == CMD_PITCH) ? ISSUE : SCAN;
          end
        end
        SCAN: begin
          if (cur_match && !match_found_reg) begin
            match_found_reg <= 1'b1;
            match_idx_reg   <= scan_idx_reg;
          end
          if (!cur_active && !free_found_reg) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= scan_idx_reg;
          end
          // Fixed-length scan: constant latency regardless of where a hit lies.
          if (scan_idx_reg == IW'(NUM_VOICES - 1)) begin
            state_reg <= ISSUE;
          end else begin
            scan_idx_reg <= scan_idx_reg + 1'b1;
          end
        end
        ISSUE: begin
          state_reg <= IDLE;
          case (ev_cmd_reg)
            CMD_ON: begin
              note_pressed <= 1'b1;
              addr         <= 8'(on_slot);
              note         <= ev_note_reg;
              velocity     <= ev_vel_reg;
              channel      <= ev_chan_reg;
              if (!match_found_reg && free_found_reg) begin
                voices_active <= voices_active + 8'd1;
              end
              if (use_steal) begin
                steal_ptr_reg <= (steal_ptr_reg == IW'(NUM_VOICES - 1)) ? '0 :
                                 steal_ptr_reg + 1'b1;
              end
            end
            CMD_OFF: begin
              if (match_found_reg) begin
                note_released <= 1'b1;
                addr          <= 8'(match_idx_reg);
                note          <= ev_note_reg;
                velocity      <= ev_vel_reg;
                channel       <= ev_chan_reg;
                voices_active <= voices_active - 8'd1;
              end
            end
            CMD_POLY: begin
              if (match_found_reg) begin
                note_keypress <= 1'b1;
                addr          <= 8'(match_idx_reg);
                note          <= ev_note_reg;
                velocity      <= ev_vel_reg;
                channel       <= ev_chan_reg;
              end
            end
            default: begin
              pitch_wheel <= 1'b1;
              addr        <= 8'd0;
              note        <= ev_note_reg;
              velocity    <= ev_vel_reg;
              channel     <= ev_chan_reg;
            end
          endcase
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: self-checking bench for voice_alloc with NUM_VOICES=32.
// Expected pulses are queued when an event is driven. A negedge monitor pops
// and compares each pulse against the queue, including its timing.
module tb_voice_alloc;

  localparam int NV = 32;

  logic       clk96 = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_cmd;
  logic [3:0] in_channel;
  logic [6:0] in_note;
  logic [6:0] in_velocity;
  logic       note_pressed;
  logic       note_released;
  logic       note_keypress;
  logic       pitch_wheel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic [7:0] addr;
  logic [7:0] voices_active;

  voice_alloc #(.NUM_VOICES(NV)) dut (
    .clk96(clk96), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_channel(in_channel), .in_note(in_note), .in_velocity(in_velocity),
    .note_pressed(note_pressed), .note_released(note_released),
    .note_keypress(note_keypress), .pitch_wheel(pitch_wheel),
    .note(note), .velocity(velocity), .channel(channel), .addr(addr),
    .voices_active(voices_active)
  );

  always #5 clk96 = ~clk96;

  // Pulse kinds: 1 pressed, 2 released, 3 keypress, 4 pitch
  typedef struct {
    int kind;
    int addr;
    int note;
    int vel;
    int chan;
    int va;
    int cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk96) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of the queue.
  exp_t m_e;
  int   m_np;
  int   m_kind;
  always @(negedge clk96) begin
    if (rst === 1'b0) begin
      m_np = int'(note_pressed) + int'(note_released) + int'(note_keypress) + int'(pitch_wheel);
      if (m_np != 0) begin
        m_kind = note_pressed ? 1 : note_released ? 2 : note_keypress ? 3 : 4;
        total++;
        if (m_np > 1) begin
          bad++;
          $display("FAIL onehot pulses=%0d want=1 cyc=%0d", m_np, cyc);
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse kind=%0d addr=%0d cyc=%0d", m_kind, addr, cyc);
        end else begin
          m_e = q.pop_front();
          $display("pulse kind=%0d addr=%0d note=%0d vel=%0d ch=%0d va=%0d cyc=%0d",
                   m_kind, addr, note, velocity, channel, voices_active, cyc);
          total++;
          if (m_kind !== m_e.kind) begin bad++; $display("FAIL kind got=%0d want=%0d", m_kind, m_e.kind); end
          total++;
          if (int'(addr) !== m_e.addr) begin bad++; $display("FAIL addr got=%0d want=%0d", addr, m_e.addr); end
          total++;
          if (int'(note) !== m_e.note) begin bad++; $display("FAIL note got=%0d want=%0d", note, m_e.note); end
          total++;
          if (int'(velocity) !== m_e.vel) begin bad++; $display("FAIL velocity got=%0d want=%0d", velocity, m_e.vel); end
          total++;
          if (int'(channel) !== m_e.chan) begin bad++; $display("FAIL channel got=%0d want=%0d", channel, m_e.chan); end
          total++;
          if (int'(voices_active) !== m_e.va) begin bad++; $display("FAIL voices_active got=%0d want=%0d", voices_active, m_e.va); end
          total++;
          if (cyc !== m_e.cyc) begin bad++; $display("FAIL latency cyc got=%0d want=%0d", cyc, m_e.cyc); end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk96);
    rst = 1'b0;
    @(negedge clk96);
  endtask

  // Drive one event at a negedge and wait for the block to go idle again.
  // kind=0 means that no pulse is expected. acc is the accept edge. rdy is the
  // cycle in which in_ready returns.
  task automatic send(input int cmd, input int ch, input int nt, input int vel,
                      input int kind, input int eaddr, input int eva,
                      output int acc, output int rdy);
    exp_t e;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk96); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL ready_before_send got=0 want=1"); end
    acc = cyc + 1;
    if (kind != 0) begin
      e.kind = kind; e.addr = eaddr; e.note = nt; e.vel = vel; e.chan = ch; e.va = eva;
      e.cyc = acc + ((cmd == 3) ? 1 : NV + 1);
      q.push_back(e);
    end
    in_valid = 1'b1;
    in_cmd = 2'(cmd);
    in_channel = 4'(ch);
    in_note = 7'(nt);
    in_velocity = 7'(vel);
    @(negedge clk96);
    in_valid = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk96); n++; end
    rdy = cyc;
    total++;
    if (n >= 100) begin bad++; $display("FAIL ready_after_event got=0 want=1"); end
    $display("event cmd=%0d ch=%0d note=%0d vel=%0d accepted_cyc=%0d ready_cyc=%0d", cmd, ch, nt, vel, acc, rdy);
    @(negedge clk96);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++;
    if (voices_active !== 8'd0) begin bad++; $display("FAIL reset_voices_active got=%0d want=0", voices_active); end
    total++;
    if (addr !== 8'd0 || note !== 7'd0 || velocity !== 7'd0 || channel !== 4'd0) begin
      bad++; $display("FAIL reset_fields addr=%0d note=%0d vel=%0d ch=%0d want=0", addr, note, velocity, channel);
    end
    total++;
    if ({note_pressed, note_released, note_keypress, pitch_wheel} !== 4'b0) begin
      bad++; $display("FAIL reset_pulses got=%b want=0000", {note_pressed, note_released, note_keypress, pitch_wheel});
    end
  endtask

  task automatic test_note_on();
    int a, r;
    send(0, 2, 60, 100, 1, 0, 1, a, r);
  endtask

  task automatic test_retrigger();
    int a, r;
    send(0, 2, 60, 80, 1, 0, 1, a, r);
  endtask

  task automatic test_vel0_drop();
    int a, r;
    send(0, 2, 64, 0, 0, 0, 0, a, r);
    // in_ready is back on the 34th cycle when the accept cycle is counted as cycle 1.
    total++;
    if (r - a !== NV + 1) begin bad++; $display("FAIL vel0_ready_latency got=%0d want=%0d", r - a, NV + 1); end
    total++;
    if (voices_active !== 8'd1) begin bad++; $display("FAIL vel0_voices_active got=%0d want=1", voices_active); end
    // The slot for ch2 note60 must still be held.
    send(2, 2, 60, 33, 3, 0, 1, a, r);
  endtask

  task automatic test_note_off();
    int a, r;
    send(1, 2, 60, 40, 2, 0, 0, a, r);
    send(2, 2, 60, 20, 0, 0, 0, a, r);
    total++;
    if (voices_active !== 8'd0) begin bad++; $display("FAIL off_voices_active got=%0d want=0", voices_active); end
  endtask

  task automatic test_channel_distinct();
    int a, r;
    send(0, 3, 60, 50, 1, 0, 1, a, r);
    send(0, 2, 60, 51, 1, 1, 2, a, r);
    send(0, 2, 60, 0, 2, 1, 1, a, r);
  endtask

  task automatic test_pitch();
    int a, r;
    send(3, 5, 8'h50, 7'h11, 4, 0, 1, a, r);
  endtask

  task automatic test_steal();
    int a, r;
    do_reset();
    for (int i = 0; i < NV; i++) send(0, 1, i, 10 + i, 1, i, i + 1, a, r);
    send(0, 1, 100, 90, 1, 0, NV, a, r);
    send(0, 1, 101, 91, 1, 1, NV, a, r);
    send(1, 1, 0, 5, 0, 0, 0, a, r);
    send(1, 1, 5, 5, 2, 5, NV - 1, a, r);
    send(0, 1, 102, 92, 1, 5, NV, a, r);
    send(0, 1, 103, 93, 1, 2, NV, a, r);
  endtask

  task automatic test_rst_mid_scan();
    int a, r;
    do_reset();
    in_valid = 1'b1; in_cmd = 2'd0; in_channel = 4'd3; in_note = 7'd10; in_velocity = 7'd50;
    @(negedge clk96);
    in_valid = 1'b0;
    repeat (10) @(negedge clk96);
    rst = 1'b1;
    @(negedge clk96);
    rst = 1'b0;
    @(negedge clk96);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%0b want=1", in_ready); end
    repeat (40) @(negedge clk96);
    total++;
    if (voices_active !== 8'd0) begin bad++; $display("FAIL rst_mid_voices_active got=%0d want=0", voices_active); end
    send(0, 3, 10, 50, 1, 0, 1, a, r);
  endtask

  task automatic test_back_to_back();
    int a, r;
    do_reset();
    send(0, 0, 1, 70, 1, 0, 1, a, r);
    send(0, 0, 2, 71, 1, 1, 2, a, r);
    send(2, 0, 2, 72, 3, 1, 2, a, r);
    send(1, 0, 1, 73, 2, 0, 1, a, r);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_cmd = 2'd0;
    in_channel = 4'd0;
    in_note = 7'd0;
    in_velocity = 7'd0;
    test_reset();
    test_note_on();
    test_retrigger();
    test_vel0_drop();
    test_note_off();
    test_channel_distinct();
    test_pitch();
    test_steal();
    test_rst_mid_scan();
    test_back_to_back();
    repeat (5) @(negedge clk96);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL missing_pulses got=%0d want=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 32, giving the number of voice slots (legal range 2..128).
REQ-002 SHALL have port clk96  input  1  system clock, 96 MHz.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high; clock clk96.
REQ-004 SHALL have port in_valid  input  1  a MIDI event is present on the in_* ports.
REQ-005 SHALL have port in_ready  output  1  the block accepts an event when in_valid && in_ready.
REQ-006 SHALL have port in_cmd  input  2  event code: 0=NOTE_ON, 1=NOTE_OFF, 2=POLY_AT, 3=PITCH.
REQ-007 SHALL have port in_channel  input  4  MIDI channel.
REQ-008 SHALL have port in_note  input  7  note number; for PITCH, the pitch-bend MSB.
REQ-009 SHALL have port in_velocity  input  7  velocity or aftertouch pressure.
REQ-010 SHALL have ports note_pressed, note_released, note_keypress and pitch_wheel, each output 1, each a one-cycle pulse to the synth.
REQ-011 SHALL have ports note (output 7), velocity (output 7), channel (output 4) and addr (output 8), carrying the event fields and the voice slot.
REQ-012 SHALL have port voices_active  output  8  count of occupied slots.

Function
REQ-013 SHALL hold one slot table per voice: active bit, channel[3:0], note[6:0].
REQ-014 SHALL implement FSM IDLE -> SCAN -> ISSUE -> IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL handle NOTE_ON with in_velocity==0 exactly as NOTE_OFF.
REQ-017 SHALL, on acceptance of a PITCH event, issue pitch_wheel in ISSUE the next cycle with note=in_note, channel=in_channel and addr=0, skipping SCAN.
REQ-018 SHALL, on NOTE_ON/NOTE_OFF/POLY_AT acceptance, latch the event and enter SCAN, examining one slot per cycle for indices 0..NUM_VOICES-1, always NUM_VOICES cycles (no early exit).
REQ-019 SHALL record during SCAN the lowest-index active slot matching (channel, note) and the lowest-index inactive slot.
REQ-020 SHALL select the NOTE_ON slot with priority: match (retrigger), then lowest free slot, then steal_ptr.
REQ-021 SHALL, when it uses steal_ptr, advance steal_ptr by 1 modulo NUM_VOICES; steal_ptr SHALL be unchanged otherwise.
REQ-022 SHALL, for NOTE_ON in ISSUE, pulse note_pressed with addr=slot, set the slot active with the latched channel/note, and increment voices_active only if the slot was free.
REQ-023 SHALL, for NOTE_OFF with a match, pulse note_released with addr=match and clear that slot's active bit (decrementing voices_active).
REQ-024 SHALL, for NOTE_OFF without a match, drop the event with no pulse.
REQ-025 SHALL, for POLY_AT with a match, pulse note_keypress with addr=match and the table unchanged.
REQ-026 SHALL, for POLY_AT without a match, drop the event.
REQ-027 SHALL set the latency (accept edge to pulse) to NUM_VOICES+1 cycles for note events and 1 cycle for PITCH.
REQ-028 SHALL return in_ready high in the cycle after ISSUE.
REQ-029 SHALL assert at most one pulse output per cycle.
REQ-030 SHALL hold note/velocity/channel/addr stable from ISSUE until the next ISSUE.
REQ-031 SHALL ignore in_* while in_ready=0; the upstream stage holds events.
REQ-032 SHALL never exceed NUM_VOICES or go below 0 for voices_active.

Reset
REQ-033 SHALL, on rst, clear all active bits, set steal_ptr=0, voices_active=0, FSM=IDLE, all pulse outputs 0, and note/velocity/channel/addr=0.
REQ-034 SHALL, on rst asserted mid-SCAN or mid-ISSUE, abort the event with no pulse in that or the following cycle.
REQ-035 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Verification (NUM_VOICES=32)
REQ-036 SHALL cover: NOTE_ON ch2 note60 vel100 after reset -> 33 cycles later note_pressed, addr=0, voices_active=1.
REQ-037 SHALL cover: second NOTE_ON ch2 note60 vel80 -> note_pressed addr=0 (retrigger), velocity=80, voices_active stays 1.
REQ-038 SHALL cover: NOTE_ON ch2 note64 vel0 with no match -> no pulse, table unchanged, in_ready back high after 34 cycles.
REQ-039 SHALL cover: 33 distinct NOTE_ONs -> 33rd issues addr=0 via steal, steal_ptr=1, voices_active=32; 34th steals addr=1.
REQ-040 SHALL cover: NOTE_OFF ch2 note60 after REQ-036 -> note_released addr=0, voices_active=0; POLY_AT on an unheld note -> no pulse.
REQ-041 SHALL cover: PITCH ch5 in_note=0x50 -> pitch_wheel next cycle, note=0x50, channel=5; rst mid-SCAN -> no pulse, voices_active=0.
